// File: rtl/ps2_keyboard_matrix.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_keyboard_matrix
//  Purpose  : PS/2 (scan-code set 2) keyboard front end for a C64 CIA #1.
//             Receives PS/2 frames, keeps the 8x8 C64 key matrix
//             (column = PA bit, row = PB bit) and answers the CIA column
//             drive with registered row levels. PgUp acts as RESTORE.
//  Ports    : clk        in   peripheral clock
//             reset_n    in   asynchronous active-low reset
//             ps2_clk    in   PS/2 clock (async, idle high)
//             ps2_data   in   PS/2 data (async)
//             pa_out[7:0] in  CIA port A; bit c low selects column c
//             pb_row[7:0] out row levels to CIA pb_in; low = pressed key
//             restore_n  out  low while RESTORE is held
//             frame_err  out  1-clk pulse on start/parity/stop error or timeout
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_keyboard_matrix #(
    parameter int CLK_FREQ    = 4000000,
    parameter int TIMEOUT_CYC = CLK_FREQ / 1000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [7:0] pa_out,
    output logic [7:0] pb_row,
    output logic       restore_n,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_BITS, RX_PAR, RX_STOP} rx_state_t;

    // ------------------------------------------------------------------
    // Synchronisers and clock glitch filter
    // ------------------------------------------------------------------
    logic [1:0] clk_sync_q, dat_sync_q;
    logic       filt_clk_q;
    logic [2:0] filt_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_clk_q <= 1'b1;
            filt_cnt_q <= 3'd0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
            // The filtered clock follows only after 8 consecutive differing samples
            if (clk_sync_q[1] == filt_clk_q) begin
                filt_cnt_q <= 3'd0;
            end else if (filt_cnt_q == 3'd7) begin
                filt_clk_q <= clk_sync_q[1];
                filt_cnt_q <= 3'd0;
            end else begin
                filt_cnt_q <= filt_cnt_q + 3'd1;
            end
        end
    end

    logic w_edge, w_fall, w_bit;
    assign w_edge = (clk_sync_q[1] != filt_clk_q) && (filt_cnt_q == 3'd7);
    assign w_fall = w_edge && filt_clk_q;
    assign w_bit  = dat_sync_q[1];

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    rx_state_t   rx_state_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic        par_ok_q;
    logic [TW-1:0] to_cnt_q;
    logic        byte_stb_q;
    logic [7:0]  byte_q;
    logic        frame_err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_q  <= RX_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            par_ok_q    <= 1'b0;
            to_cnt_q    <= '0;
            byte_stb_q  <= 1'b0;
            byte_q      <= 8'h00;
            frame_err_q <= 1'b0;
        end else begin
            byte_stb_q  <= 1'b0;
            frame_err_q <= 1'b0;
            if (rx_state_q == RX_IDLE || w_edge) begin
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + TW'(1);
            end

            if (w_fall) begin
                case (rx_state_q)
                    RX_IDLE: begin
                        if (!w_bit) begin
                            rx_state_q <= RX_BITS;
                            bit_cnt_q  <= 3'd0;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    RX_BITS: begin
                        shift_q   <= {w_bit, shift_q[7:1]};   // LSB arrives first
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_state_q <= RX_PAR;
                        end
                    end
                    RX_PAR: begin
                        par_ok_q   <= ^{shift_q, w_bit};      // odd parity -> XOR is 1
                        rx_state_q <= RX_STOP;
                    end
                    default: begin
                        if (w_bit && par_ok_q) begin
                            byte_stb_q <= 1'b1;
                            byte_q     <= shift_q;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        rx_state_q <= RX_IDLE;
                    end
                endcase
            end else if (rx_state_q != RX_IDLE && to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                frame_err_q <= 1'b1;
                rx_state_q  <= RX_IDLE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Set-2 lookup: returns {valid, col[2:0], row[2:0]} for key {ext, code}
    // ------------------------------------------------------------------
    function automatic logic [6:0] lookup(input logic [8:0] k);
        logic [6:0] m;
        m = 7'd0;
        case (k)
            9'h066: m = 7'o100; 9'h05A: m = 7'o101; 9'h174: m = 7'o102; 9'h083: m = 7'o103;
            9'h005: m = 7'o104; 9'h004: m = 7'o105; 9'h003: m = 7'o106; 9'h172: m = 7'o107;
            9'h026: m = 7'o110; 9'h01D: m = 7'o111; 9'h01C: m = 7'o112; 9'h025: m = 7'o113;
            9'h01A: m = 7'o114; 9'h01B: m = 7'o115; 9'h024: m = 7'o116; 9'h012: m = 7'o117;
            9'h02E: m = 7'o120; 9'h02D: m = 7'o121; 9'h023: m = 7'o122; 9'h036: m = 7'o123;
            9'h021: m = 7'o124; 9'h02B: m = 7'o125; 9'h02C: m = 7'o126; 9'h022: m = 7'o127;
            9'h03D: m = 7'o130; 9'h035: m = 7'o131; 9'h034: m = 7'o132; 9'h03E: m = 7'o133;
            9'h032: m = 7'o134; 9'h033: m = 7'o135; 9'h03C: m = 7'o136; 9'h02A: m = 7'o137;
            9'h046: m = 7'o140; 9'h043: m = 7'o141; 9'h03B: m = 7'o142; 9'h045: m = 7'o143;
            9'h03A: m = 7'o144; 9'h042: m = 7'o145; 9'h044: m = 7'o146; 9'h031: m = 7'o147;
            9'h04E: m = 7'o150; 9'h04D: m = 7'o151; 9'h04B: m = 7'o152; 9'h055: m = 7'o153;
            9'h049: m = 7'o154; 9'h04C: m = 7'o155; 9'h054: m = 7'o156; 9'h041: m = 7'o157;
            9'h170: m = 7'o160; 9'h05B: m = 7'o161; 9'h052: m = 7'o162; 9'h16C: m = 7'o163;
            9'h059: m = 7'o164; 9'h05D: m = 7'o165; 9'h171: m = 7'o166; 9'h04A: m = 7'o167;
            9'h016: m = 7'o170; 9'h00E: m = 7'o171; 9'h014: m = 7'o172; 9'h01E: m = 7'o173;
            9'h029: m = 7'o174; 9'h011: m = 7'o175; 9'h015: m = 7'o176; 9'h076: m = 7'o177;
            default: m = 7'd0;
        endcase
        return m;
    endfunction

    // ------------------------------------------------------------------
    // Decoder and key matrix (key[c] holds the row bits of column c)
    // ------------------------------------------------------------------
    logic [7:0][7:0] key_q, key_d;
    logic            ext_q, ext_d, brk_q, brk_d, restore_q, restore_d;
    logic [2:0]      skip_q, skip_d;
    logic [6:0]      w_map;
    logic [7:0]      w_rows;
    logic [7:0]      pb_row_q;

    assign w_map = lookup({ext_q, byte_q});

    always_comb begin
        key_d     = key_q;
        ext_d     = ext_q;
        brk_d     = brk_q;
        skip_d    = skip_q;
        restore_d = restore_q;
        if (byte_stb_q) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;           // swallowing the Pause sequence
            end else begin
                case (byte_q)
                    8'hE1: skip_d = 3'd7;
                    8'hE0: ext_d  = 1'b1;
                    8'hF0: brk_d  = 1'b1;
                    8'hAA, 8'hFC, 8'h00: begin
                        key_d = '0;
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                    default: begin
                        if (w_map[6]) begin
                            key_d[w_map[5:3]][w_map[2:0]] = ~brk_q;
                        end
                        if ({ext_q, byte_q} == 9'h17D) begin
                            restore_d = ~brk_q;
                        end
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                endcase
            end
        end
    end

    // Rows are built from key_d so a matrix update and a pa_out change in
    // the same clk both show up on the next pb_row value.
    assign w_rows = ~(({8{~pa_out[0]}} & key_d[0]) | ({8{~pa_out[1]}} & key_d[1]) |
                      ({8{~pa_out[2]}} & key_d[2]) | ({8{~pa_out[3]}} & key_d[3]) |
                      ({8{~pa_out[4]}} & key_d[4]) | ({8{~pa_out[5]}} & key_d[5]) |
                      ({8{~pa_out[6]}} & key_d[6]) | ({8{~pa_out[7]}} & key_d[7]));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_q     <= '0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            skip_q    <= 3'd0;
            restore_q <= 1'b0;
            pb_row_q  <= 8'hFF;
        end else begin
            key_q     <= key_d;
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            skip_q    <= skip_d;
            restore_q <= restore_d;
            pb_row_q  <= w_rows;
        end
    end

    assign pb_row    = pb_row_q;
    assign restore_n = ~restore_q;
    assign frame_err = frame_err_q;

endmodule
`default_nettype wire
